instr_fetch: RTL
================

# instr_fetch

- Program-sequencing stage directly upstream of the CPU decode/execute core.
- Holds a 16-word × 12-bit program store, loaded while idle.
- Sequences a 4-bit program counter and presents one instruction at a time over a valid/ready handshake.
- Handles skip (squash next instruction) and halt (stop issuing) locally, so the execute stage never sees squashed or post-halt words.

## Interface
Parameters:
- IW, 12, instruction width (opcode [11:8], dst [7:4], src/value [3:0])
- AW, 4, program address width (depth 2^AW = 16)

Ports:
- inclk  in  1  clock; all state changes on rising edge
- reset  in  1  synchronous, active-low reset
- load_valid  in  1  write strobe for the program store; honoured only in IDLE
- load_addr  in  AW  program store write address
- load_data  in  IW  program store write data
- start  in  1  level; sampled in IDLE or HALT, begins execution at pc 0
- skip  in  1  from execute: squash the currently presented instruction
- instr  out  IW  presented instruction
- instr_valid  out  1  instr is valid for transfer
- instr_ready  in  1  execute stage accepts instr this cycle
- pc  out  AW  address of the presented instruction
- running  out  1  state == RUN
- halted  out  1  state == HALT

## Operation
- States: IDLE, RUN, HALT.
- Reset (reset=0 at an edge) → IDLE.
  - Outputs after reset: instr=0, instr_valid=0, pc=0, running=0, halted=0.
  - Program store is NOT cleared; contents survive reset.
- IDLE:
  - load_valid=1 writes mem[load_addr] <= load_data.
  - start=1 → RUN with pc<=0, instr<=mem[0], instr_valid<=1.
  - If load_valid and start are both high in the same cycle, the write completes first. instr reflects the new data when load_addr==0.
- RUN:
  - load_valid is ignored.
  - Transfer = instr_valid & instr_ready & !skip.
  - On transfer of a non-halt opcode: pc <= pc+1 (15 wraps to 0), instr <= mem[pc+1], instr_valid stays 1. Back-to-back transfers at one per cycle are supported.
  - On transfer of opcode OP_HALT (4'hF): → HALT, instr_valid<=0, instr<=0. pc holds the halt instruction's address.
  - skip=1 while instr_valid=1: the presented word is discarded even if instr_ready=1. This is not a transfer, even if the discarded word is OP_HALT.
    - Squash cycle: pc <= pc+1, instr <= mem[pc+1], instr_valid <= 0 for exactly one cycle (bubble).
    - Next cycle: instr_valid returns to 1.
  - skip=1 while instr_valid=0 is ignored.
  - instr_valid=1 & instr_ready=0 & skip=0: instr and pc hold stable.
- HALT:
  - instr_valid=0, halted=1.
  - start=1 → RUN from pc 0, identical to the IDLE start.
  - load_valid is ignored.
- reset=0 in any state, including mid-transfer, overrides all other inputs on that edge.

## Timing
- All outputs are registered; no combinational input→output paths.
- start at edge N → instr_valid=1, pc=0 after edge N (1-cycle latency).
- Transfer at edge N → next word presented after edge N (zero bubbles).
- Squash at edge N → instr_valid=0 during cycle N+1, valid again after edge N+1.
- Halt transfer at edge N → halted=1, instr_valid=0 after edge N.
- Program store read is combinational from the registered pc+1 and feeds the instr register. A store write becomes visible to fetch on the next edge.

## Structure
- Shared package cpu_pkg holds:
  - IW, AW
  - OP_HALT=4'hF, OP_SKIPIF=4'hE
  - state enum {IDLE, RUN, HALT}
- The decoder and execute stage import the same opcode constants.
- One sub-module: prog_mem. 16×12 register array, one synchronous write port, one asynchronous read port, no reset.
- FSM, pc, and output registers live in instr_fetch.

## Test plan
- Load mem[0..2]={12'h7A3,12'h012,12'hF00}, start, instr_ready=1 → instr 7A3 (pc0), 012 (pc1), F00 (pc2) on consecutive cycles, then halted=1, instr_valid=0, pc=2.
- Same program, instr_ready low 3 cycles at pc1 → instr=012 and pc=1 held stable; resumes on ready with no word lost or duplicated.
- mem[1]=12'hE05, mem[2]=12'h7FF, mem[3]=12'hF00; assert skip the cycle after E05 transfers → 7FF never transferred, one bubble, F00 at pc3 transfers, halt.
- Program of 16 non-halt words 12'h1n0 (n = address), continuous ready → pc runs 0..15 then wraps to 0, instr=100 again.
- reset=0 mid-run at pc5 → next cycle instr_valid=0, pc=0, running=0. Then start → first instr equals pre-reset mem[0], confirming the store was retained.
- load_valid during RUN to addr 0 with 12'hABC → store unchanged; after halt and restart, original mem[0] is presented.

Source files
------------

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared widths, opcodes and fetch states for the CPU pipeline
package cpu_pkg;
    localparam int IW = 12;
    localparam int AW = 4;
    localparam logic [3:0] OP_HALT   = 4'hF;
    localparam logic [3:0] OP_SKIPIF = 4'hE;
    typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;
endpackage

// File: rtl/prog_mem.sv
// prog_mem: 2^AW x IW program store, sync write / async read, no reset
// Ports: inclk clock; we/waddr/wdata write port; raddr/rdata combinational read port
module prog_mem #(
    parameter int IW = cpu_pkg::IW,
    parameter int AW = cpu_pkg::AW
) (
    input  logic          inclk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [IW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [IW-1:0] rdata
);
    logic [IW-1:0] mem [2**AW];

    always_ff @(posedge inclk)
        if (we) mem[waddr] <= wdata;

    assign rdata = mem[raddr];
endmodule

// File: rtl/instr_fetch.sv
// instr_fetch: program sequencer presenting one instruction per valid/ready handshake
// Ports: inclk clock; reset sync active-low; load_* program store write (IDLE only);
//        start begins at pc 0; skip squashes the presented word; instr/instr_valid/instr_ready
//        handshake; pc address of instr; running/halted state flags
module instr_fetch #(
    parameter int IW = cpu_pkg::IW,
    parameter int AW = cpu_pkg::AW
) (
    input  logic          inclk,
    input  logic          reset,
    input  logic          load_valid,
    input  logic [AW-1:0] load_addr,
    input  logic [IW-1:0] load_data,
    input  logic          start,
    input  logic          skip,
    output logic [IW-1:0] instr,
    output logic          instr_valid,
    input  logic          instr_ready,
    output logic [AW-1:0] pc,
    output logic          running,
    output logic          halted
);
    import cpu_pkg::*;

    state_t        state, state_d;
    logic [AW-1:0] pc_d, rd_addr;
    logic [IW-1:0] instr_d, rdata;
    logic          valid_d, we;

    assign we      = (state == IDLE) && load_valid;
    assign rd_addr = (state == RUN) ? pc + AW'(1) : '0;
    assign running = state == RUN;
    assign halted  = state == HALT;

    prog_mem #(.IW(IW), .AW(AW)) u_mem (
        .inclk(inclk),
        .we   (we),
        .waddr(load_addr),
        .wdata(load_data),
        .raddr(rd_addr),
        .rdata(rdata)
    );

    always_comb begin
        state_d = state;
        pc_d    = pc;
        instr_d = instr;
        valid_d = instr_valid;
        case (state)
            IDLE, HALT:
                if (start) begin
                    state_d = RUN;
                    pc_d    = '0;
                    // a same-cycle write to address 0 must be seen by the first fetch
                    instr_d = (we && load_addr == '0) ? load_data : rdata;
                    valid_d = 1'b1;
                end
            RUN:
                if (instr_valid && skip) begin
                    pc_d    = pc + AW'(1);
                    instr_d = rdata;
                    valid_d = 1'b0;
                end else if (instr_valid && instr_ready) begin
                    if (instr[IW-1 -: 4] == OP_HALT) begin
                        state_d = HALT;
                        instr_d = '0;
                        valid_d = 1'b0;
                    end else begin
                        pc_d    = pc + AW'(1);
                        instr_d = rdata;
                    end
                end else if (!instr_valid) begin
                    // end of the one-cycle squash bubble
                    valid_d = 1'b1;
                end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge inclk)
        if (!reset) begin
            state       <= IDLE;
            pc          <= '0;
            instr       <= '0;
            instr_valid <= 1'b0;
        end else begin
            state       <= state_d;
            pc          <= pc_d;
            instr       <= instr_d;
            instr_valid <= valid_d;
        end
endmodule
